// File: rtl/mem_port_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arb_pkg : shared widths, owner encoding and request/tag types      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package mem_port_arb_pkg;

    localparam int SIZE_ADDR   = 8;
    localparam int SIZE_DATA   = 16;
    localparam int SIZE_STARVE = 4;
    localparam int NUM_PORTS   = 2;

    localparam logic OWN_P = 1'b0;
    localparam logic OWN_A = 1'b1;

    typedef struct packed {
        logic                 we;
        logic [SIZE_ADDR-1:0] addr;
        logic [SIZE_DATA-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic valid;
        logic is_aux;
    } own_tag_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arb_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arb_ch : per-bank grant, starvation counter, read-owner tag        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mem_port_arb_ch
    import mem_port_arb_pkg::*;
#(
    parameter int P_STARVE_MAX = 4
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst_n,
    input  logic                 iw_p_req,
    input  mem_req_t             iw_p_cmd,
    input  logic                 iw_a_req,
    input  mem_req_t             iw_a_cmd,
    output logic                 ow_p_gnt,
    output logic                 ow_a_gnt,
    output logic                 ow_forced,
    output logic                 ow_mem_en,
    output logic                 ow_mem_we,
    output logic [SIZE_ADDR-1:0] ow_mem_addr,
    output logic [SIZE_DATA-1:0] ow_mem_wdata,
    output own_tag_t             ow_tag
);

    localparam logic [SIZE_STARVE-1:0] C_STARVE_MAX = SIZE_STARVE'(P_STARVE_MAX);

    logic [SIZE_STARVE-1:0] r_cnt;
    own_tag_t               r_tag;
    logic                   w_both;
    logic                   w_forced;
    logic                   w_p_gnt;
    logic                   w_a_gnt;
    mem_req_t               w_sel;

    // Outputs are gated by reset so the bank stays quiet while rst_n is low.
    always_comb begin
        w_both   = iw_rst_n & iw_p_req & iw_a_req;
        w_forced = w_both & (r_cnt == C_STARVE_MAX);
        w_p_gnt  = iw_rst_n & iw_p_req & ~w_forced;
        w_a_gnt  = iw_rst_n & iw_a_req & (~iw_p_req | w_forced);
        w_sel    = '0;
        if (w_a_gnt) begin
            w_sel = iw_a_cmd;
        end else if (w_p_gnt) begin
            w_sel = iw_p_cmd;
        end
    end

    assign ow_p_gnt     = w_p_gnt;
    assign ow_a_gnt     = w_a_gnt;
    assign ow_forced    = w_forced;
    assign ow_mem_en    = w_p_gnt | w_a_gnt;
    assign ow_mem_we    = w_sel.we;
    assign ow_mem_addr  = w_sel.addr;
    assign ow_mem_wdata = w_sel.wdata;
    assign ow_tag       = r_tag;

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_cnt <= '0;
            r_tag <= '0;
        end else begin
            // A non-forced conflict implies r_cnt < max, so the count saturates at max.
            if (w_both && !w_forced) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            r_tag.valid  <= (w_p_gnt | w_a_gnt) & ~w_sel.we;
            r_tag.is_aux <= w_a_gnt ? OWN_A : OWN_P;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arb : two-bank arbiter between pipeline (P) and aux (A) requesters |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int P_STARVE_MAX = 4
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst_n,
    input  logic                 iw_p_req,
    input  logic                 iw_p_mp,
    input  logic                 iw_p_we,
    input  logic [SIZE_ADDR-1:0] iw_p_addr,
    input  logic [SIZE_DATA-1:0] iw_p_wdata,
    output logic                 ow_p_stall,
    output logic                 ow_p_rvalid,
    output logic [SIZE_DATA-1:0] ow_p_rdata,
    input  logic                 iw_a_valid,
    output logic                 ow_a_ready,
    input  logic                 iw_a_mp,
    input  logic                 iw_a_we,
    input  logic [SIZE_ADDR-1:0] iw_a_addr,
    input  logic [SIZE_DATA-1:0] iw_a_wdata,
    output logic                 ow_a_rvalid,
    output logic [SIZE_DATA-1:0] ow_a_rdata,
    output logic                 ow_mem_en    [0:NUM_PORTS-1],
    output logic                 ow_mem_we    [0:NUM_PORTS-1],
    output logic [SIZE_ADDR-1:0] ow_mem_addr  [0:NUM_PORTS-1],
    output logic [SIZE_DATA-1:0] ow_mem_wdata [0:NUM_PORTS-1],
    input  logic [SIZE_DATA-1:0] iw_mem_rdata [0:NUM_PORTS-1]
);

    mem_req_t               w_p_cmd;
    mem_req_t               w_a_cmd;
    logic [NUM_PORTS-1:0]   w_p_hit;
    logic [NUM_PORTS-1:0]   w_a_hit;
    logic [NUM_PORTS-1:0]   w_p_gnt;
    logic [NUM_PORTS-1:0]   w_a_gnt;
    logic [NUM_PORTS-1:0]   w_forced;
    own_tag_t               w_tag [0:NUM_PORTS-1];

    assign w_p_cmd = '{we: iw_p_we, addr: iw_p_addr, wdata: iw_p_wdata};
    assign w_a_cmd = '{we: iw_a_we, addr: iw_a_addr, wdata: iw_a_wdata};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_p_hit[gi] = iw_p_req   & (iw_p_mp == 1'(gi));
            assign w_a_hit[gi] = iw_a_valid & (iw_a_mp == 1'(gi));

            mem_port_arb_ch #(
                .P_STARVE_MAX (P_STARVE_MAX)
            ) u_ch (
                .iw_clk       (iw_clk),
                .iw_rst_n     (iw_rst_n),
                .iw_p_req     (w_p_hit[gi]),
                .iw_p_cmd     (w_p_cmd),
                .iw_a_req     (w_a_hit[gi]),
                .iw_a_cmd     (w_a_cmd),
                .ow_p_gnt     (w_p_gnt[gi]),
                .ow_a_gnt     (w_a_gnt[gi]),
                .ow_forced    (w_forced[gi]),
                .ow_mem_en    (ow_mem_en[gi]),
                .ow_mem_we    (ow_mem_we[gi]),
                .ow_mem_addr  (ow_mem_addr[gi]),
                .ow_mem_wdata (ow_mem_wdata[gi]),
                .ow_tag       (w_tag[gi])
            );
        end
    endgenerate

    assign ow_p_stall = |w_forced;
    assign ow_a_ready = |w_a_gnt;

    // At most one port carries each owner tag, so a priority scan is a plain mux.
    always_comb begin
        ow_p_rvalid = 1'b0;
        ow_p_rdata  = '0;
        ow_a_rvalid = 1'b0;
        ow_a_rdata  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_tag[k].valid && (w_tag[k].is_aux == OWN_P)) begin
                ow_p_rvalid = 1'b1;
                ow_p_rdata  = iw_mem_rdata[k];
            end
            if (w_tag[k].valid && (w_tag[k].is_aux == OWN_A)) begin
                ow_a_rvalid = 1'b1;
                ow_a_rdata  = iw_mem_rdata[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arb : directed + random bench against a scoreboard model        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_port_arb;
    import mem_port_arb_pkg::*;

    localparam int P_STARVE_MAX = 4;
    localparam int DEPTH        = 1 << SIZE_ADDR;

    logic                 iw_clk = 1'b0;
    logic                 iw_rst_n;
    logic                 iw_p_req, iw_p_mp, iw_p_we;
    logic [SIZE_ADDR-1:0] iw_p_addr;
    logic [SIZE_DATA-1:0] iw_p_wdata;
    logic                 ow_p_stall, ow_p_rvalid;
    logic [SIZE_DATA-1:0] ow_p_rdata;
    logic                 iw_a_valid, ow_a_ready, iw_a_mp, iw_a_we;
    logic [SIZE_ADDR-1:0] iw_a_addr;
    logic [SIZE_DATA-1:0] iw_a_wdata;
    logic                 ow_a_rvalid;
    logic [SIZE_DATA-1:0] ow_a_rdata;
    logic                 ow_mem_en    [0:1];
    logic                 ow_mem_we    [0:1];
    logic [SIZE_ADDR-1:0] ow_mem_addr  [0:1];
    logic [SIZE_DATA-1:0] ow_mem_wdata [0:1];
    logic [SIZE_DATA-1:0] iw_mem_rdata [0:1];

    mem_port_arb #(.P_STARVE_MAX(P_STARVE_MAX)) dut (
        .iw_clk(iw_clk), .iw_rst_n(iw_rst_n),
        .iw_p_req(iw_p_req), .iw_p_mp(iw_p_mp), .iw_p_we(iw_p_we),
        .iw_p_addr(iw_p_addr), .iw_p_wdata(iw_p_wdata),
        .ow_p_stall(ow_p_stall), .ow_p_rvalid(ow_p_rvalid), .ow_p_rdata(ow_p_rdata),
        .iw_a_valid(iw_a_valid), .ow_a_ready(ow_a_ready), .iw_a_mp(iw_a_mp),
        .iw_a_we(iw_a_we), .iw_a_addr(iw_a_addr), .iw_a_wdata(iw_a_wdata),
        .ow_a_rvalid(ow_a_rvalid), .ow_a_rdata(ow_a_rdata),
        .ow_mem_en(ow_mem_en), .ow_mem_we(ow_mem_we), .ow_mem_addr(ow_mem_addr),
        .ow_mem_wdata(ow_mem_wdata), .iw_mem_rdata(iw_mem_rdata)
    );

    always #5 iw_clk = ~iw_clk;

    function automatic logic [SIZE_DATA-1:0] init_word(int k, int i);
        return SIZE_DATA'(((k * 1237) + (i * 97)) ^ 16'h5A3C);
    endfunction

    // Synchronous-read banks driven by the DUT; filled on the first edge (DUT in reset).
    logic [SIZE_DATA-1:0] bank_mem [0:1][0:DEPTH-1];
    logic                 bank_filled = 1'b0;
    always @(posedge iw_clk) begin
        if (!bank_filled) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < DEPTH; i++)
                    bank_mem[k][i] <= init_word(k, i);
            bank_filled <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ow_mem_en[k] && ow_mem_we[k]) bank_mem[k][ow_mem_addr[k]] <= ow_mem_wdata[k];
                if (ow_mem_en[k] && !ow_mem_we[k]) iw_mem_rdata[k] <= bank_mem[k][ow_mem_addr[k]];
            end
        end
    end

    // Scoreboard state
    logic [SIZE_DATA-1:0] sb_mem [0:1][0:DEPTH-1];
    int                   starve [0:1];
    logic                 exp_p_rv, exp_a_rv;
    logic [SIZE_DATA-1:0] exp_p_rd, exp_a_rd;
    logic                 last_stall, last_ready;
    logic                 obs_a_ready, obs_p_stall, obs_p_rv, obs_a_rv;
    int                   a_wait;
    int                   n_vec, n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Checks one cycle against the model, then advances the model across the edge.
    task automatic step();
        logic                 both, a_win, p_gnt, a_gnt;
        logic                 e_en [0:1];
        logic                 e_we [0:1];
        logic [SIZE_ADDR-1:0] e_addr [0:1];
        logic [SIZE_DATA-1:0] e_wd [0:1];
        #1;
        both  = iw_p_req && iw_a_valid && (iw_p_mp == iw_a_mp);
        a_win = iw_rst_n && both && (starve[int'(iw_a_mp)] == P_STARVE_MAX);
        p_gnt = iw_rst_n && iw_p_req && !a_win;
        a_gnt = iw_rst_n && iw_a_valid && (!both || a_win);
        for (int k = 0; k < 2; k++) begin
            e_en[k] = 1'b0; e_we[k] = 1'b0; e_addr[k] = '0; e_wd[k] = '0;
        end
        if (p_gnt) begin
            e_en[iw_p_mp] = 1'b1; e_we[iw_p_mp] = iw_p_we;
            e_addr[iw_p_mp] = iw_p_addr; e_wd[iw_p_mp] = iw_p_wdata;
        end
        if (a_gnt) begin
            e_en[iw_a_mp] = 1'b1; e_we[iw_a_mp] = iw_a_we;
            e_addr[iw_a_mp] = iw_a_addr; e_wd[iw_a_mp] = iw_a_wdata;
        end
        if (!iw_rst_n) begin
            exp_p_rv = 1'b0;
            exp_a_rv = 1'b0;
        end
        chk("p_stall", 32'(ow_p_stall), 32'(a_win));
        chk("a_ready", 32'(ow_a_ready), 32'(a_gnt));
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mem_en%0d", k),    32'(ow_mem_en[k]),    32'(e_en[k]));
            chk($sformatf("mem_we%0d", k),    32'(ow_mem_we[k]),    32'(e_we[k]));
            chk($sformatf("mem_addr%0d", k),  32'(ow_mem_addr[k]),  32'(e_addr[k]));
            chk($sformatf("mem_wdata%0d", k), 32'(ow_mem_wdata[k]), 32'(e_wd[k]));
        end
        chk("p_rvalid", 32'(ow_p_rvalid), 32'(exp_p_rv));
        if (exp_p_rv) chk("p_rdata", 32'(ow_p_rdata), 32'(exp_p_rd));
        chk("a_rvalid", 32'(ow_a_rvalid), 32'(exp_a_rv));
        if (exp_a_rv) chk("a_rdata", 32'(ow_a_rdata), 32'(exp_a_rd));
        if (iw_rst_n && iw_a_valid) chk("a_wait_bound", 32'(a_wait <= P_STARVE_MAX), 32'd1);
        obs_a_ready = ow_a_ready;
        obs_p_stall = ow_p_stall;
        obs_p_rv    = ow_p_rvalid;
        obs_a_rv    = ow_a_rvalid;

        @(posedge iw_clk);
        if (!iw_rst_n) begin
            starve[0] = 0; starve[1] = 0;
            exp_p_rv = 1'b0; exp_a_rv = 1'b0;
            a_wait = 0;
        end else begin
            for (int k = 0; k < 2; k++)
                starve[k] = (both && !a_win && (k == int'(iw_a_mp))) ? starve[k] + 1 : 0;
            exp_p_rv = p_gnt && !iw_p_we;
            exp_p_rd = sb_mem[iw_p_mp][iw_p_addr];
            exp_a_rv = a_gnt && !iw_a_we;
            exp_a_rd = sb_mem[iw_a_mp][iw_a_addr];
            if (p_gnt && iw_p_we) sb_mem[iw_p_mp][iw_p_addr] = iw_p_wdata;
            if (a_gnt && iw_a_we) sb_mem[iw_a_mp][iw_a_addr] = iw_a_wdata;
            a_wait = (iw_a_valid && !obs_a_ready) ? a_wait + 1 : 0;
        end
        last_stall = a_win;
        last_ready = a_gnt;
        @(negedge iw_clk);
    endtask

    task automatic set_p(input logic req, input logic mp, input logic we,
                         input logic [SIZE_ADDR-1:0] addr, input logic [SIZE_DATA-1:0] wd);
        iw_p_req = req; iw_p_mp = mp; iw_p_we = we; iw_p_addr = addr; iw_p_wdata = wd;
    endtask

    task automatic set_a(input logic vld, input logic mp, input logic we,
                         input logic [SIZE_ADDR-1:0] addr, input logic [SIZE_DATA-1:0] wd);
        iw_a_valid = vld; iw_a_mp = mp; iw_a_we = we; iw_a_addr = addr; iw_a_wdata = wd;
    endtask

    task automatic rand_traffic(input int n);
        repeat (n) begin
            // Held requests: A until accepted, P after a stall.
            if (!iw_a_valid || last_ready)
                set_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      SIZE_ADDR'($urandom_range(0, 15)), SIZE_DATA'($urandom));
            if (!last_stall)
                set_p(1'($urandom_range(0, 4) != 0),
                      ($urandom_range(0, 4) != 0) ? iw_a_mp : 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), SIZE_ADDR'($urandom_range(0, 15)), SIZE_DATA'($urandom));
            step();
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; a_wait = 0;
        starve[0] = 0; starve[1] = 0;
        exp_p_rv = 1'b0; exp_a_rv = 1'b0; exp_p_rd = '0; exp_a_rd = '0;
        last_stall = 1'b0; last_ready = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                sb_mem[k][i] = init_word(k, i);

        // Reset held with requests active, then concurrent access on both ports.
        iw_rst_n = 1'b0;
        set_p(1'b1, 1'b0, 1'b0, 8'h10, 16'h0000);
        set_a(1'b1, 1'b1, 1'b1, 8'h20, 16'hBEEF);
        @(negedge iw_clk);
        step();
        iw_rst_n = 1'b1;
        step();
        chk("dual_a_ready", 32'(obs_a_ready), 32'd1);
        chk("dual_no_stall", 32'(obs_p_stall), 32'd0);
        set_p(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        chk("first_p_rvalid", 32'(obs_p_rv), 32'd1);

        // Continuous conflict on port 1: A forced every fifth cycle.
        set_p(1'b1, 1'b1, 1'b0, 8'h05, 16'h0000);
        set_a(1'b1, 1'b1, 1'b0, 8'h20, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("starve_ready%0d", i), 32'(obs_a_ready), 32'((i % 5) == 4));
            chk($sformatf("starve_stall%0d", i), 32'(obs_p_stall), 32'((i % 5) == 4));
        end

        // P read then A read on port 0.
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_p(1'b1, 1'b0, 1'b0, 8'h03, 16'h0000);
        step();
        set_p(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_a(1'b1, 1'b0, 1'b0, 8'h07, 16'h0000);
        step();
        chk("seq_p_rvalid", 32'(obs_p_rv), 32'd1);
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        chk("seq_a_rvalid", 32'(obs_a_rv), 32'd1);
        chk("seq_p_quiet", 32'(obs_p_rv), 32'd0);

        // Reset pulse between a read and its data cycle.
        set_p(1'b1, 1'b1, 1'b0, 8'h09, 16'h0000);
        set_a(1'b1, 1'b0, 1'b0, 8'h0A, 16'h0000);
        step();
        set_p(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        iw_rst_n = 1'b0;
        step();
        iw_rst_n = 1'b1;
        step();
        chk("rst_drop_p", 32'(obs_p_rv), 32'd0);
        chk("rst_drop_a", 32'(obs_a_rv), 32'd0);

        rand_traffic(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
